atualizador_posicao: RTL and testbench

ATUALIZADOR_POSICAO -- requirements
Module: atualizador_posicao

---
 rtl/atualizador_posicao_if.sv | 30 +++
 rtl/atualizador_posicao.sv | 112 +++++++++++
 tb/tb_atualizador_posicao.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/atualizador_posicao_if.sv
// Bundle of the command inputs and status outputs of the position updater.
// Clock and reset stay plain ports on the top module.
interface atualizador_posicao_if #(
  parameter int LARGURA = 4
);
  logic               carregar;
  logic               iniciar;
  logic [LARGURA-1:0] x_in;
  logic [LARGURA-1:0] y_in;
  logic [LARGURA-1:0] vel_x;
  logic [LARGURA-1:0] vel_y;
  logic               dir_x;
  logic               dir_y;
  logic [LARGURA-1:0] pos_x;
  logic [LARGURA-1:0] pos_y;
  logic               ocupado;
  logic               pronto;
  logic               wrap_x;
  logic               wrap_y;

  modport master (
    output carregar, iniciar, x_in, y_in, vel_x, vel_y, dir_x, dir_y,
    input  pos_x, pos_y, ocupado, pronto, wrap_x, wrap_y
  );

  modport slave (
    input  carregar, iniciar, x_in, y_in, vel_x, vel_y, dir_x, dir_y,
    output pos_x, pos_y, ocupado, pronto, wrap_x, wrap_y
  );
endinterface

// File: rtl/atualizador_posicao.sv
// Position updater: load or step an (x,y) coordinate by a signed-by-direction
// velocity, one axis per cycle, modulo 2^LARGURA with per-axis wrap flags.
module atualizador_posicao #(
  parameter int LARGURA = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  atualizador_posicao_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    FIM    = 2'd3
  } estado_t;

  estado_t            state_q, state_d;
  logic [LARGURA-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [LARGURA-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic               wrap_x_q, wrap_x_d, wrap_y_q, wrap_y_d;
  logic               ocupado_q, ocupado_d, pronto_q, pronto_d;
  logic [LARGURA:0]   r_x, r_y;

  // Extra MSB holds carry on add and borrow on subtract.
  assign r_x = dir_x_q ? ({1'b0, pos_x_q} + {1'b0, vel_x_q})
                       : ({1'b0, pos_x_q} - {1'b0, vel_x_q});
  assign r_y = dir_y_q ? ({1'b0, pos_y_q} + {1'b0, vel_y_q})
                       : ({1'b0, pos_y_q} - {1'b0, vel_y_q});

  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vel_x_d  = vel_x_q;
    vel_y_d  = vel_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    wrap_x_d = wrap_x_q;
    wrap_y_d = wrap_y_q;
    case (state_q)
      OCIOSO: begin
        if (bus.carregar) begin
          pos_x_d  = bus.x_in;
          pos_y_d  = bus.y_in;
          wrap_x_d = 1'b0;
          wrap_y_d = 1'b0;
        end else if (bus.iniciar) begin
          vel_x_d  = bus.vel_x;
          vel_y_d  = bus.vel_y;
          dir_x_d  = bus.dir_x;
          dir_y_d  = bus.dir_y;
          wrap_x_d = 1'b0;
          wrap_y_d = 1'b0;
          state_d  = CALC_X;
        end
      end
      CALC_X: begin
        pos_x_d  = r_x[LARGURA-1:0];
        wrap_x_d = r_x[LARGURA];
        state_d  = CALC_Y;
      end
      CALC_Y: begin
        pos_y_d  = r_y[LARGURA-1:0];
        wrap_y_d = r_y[LARGURA];
        state_d  = FIM;
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
    // Status flags follow the next state so they come straight from flops.
    ocupado_d = (state_d != OCIOSO);
    pronto_d  = (state_d == FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= OCIOSO;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      vel_x_q   <= '0;
      vel_y_q   <= '0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      wrap_x_q  <= 1'b0;
      wrap_y_q  <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      vel_x_q   <= vel_x_d;
      vel_y_q   <= vel_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      wrap_x_q  <= wrap_x_d;
      wrap_y_q  <= wrap_y_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign bus.pos_x   = pos_x_q;
  assign bus.pos_y   = pos_y_q;
  assign bus.wrap_x  = wrap_x_q;
  assign bus.wrap_y  = wrap_y_q;
  assign bus.ocupado = ocupado_q;
  assign bus.pronto  = pronto_q;

endmodule

// File: tb/tb_atualizador_posicao.sv
// Directed bench for atualizador_posicao: load, step, wrap, busy, reset and
// priority scenarios with hand-computed expected positions.
module tb_atualizador_posicao;
  localparam int LARGURA = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  atualizador_posicao_if #(.LARGURA(LARGURA)) bus ();

  atualizador_posicao #(.LARGURA(LARGURA)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] x, input logic [3:0] y);
    bus.x_in = x; bus.y_in = y; bus.carregar = 1'b1;
    tick();
    bus.carregar = 1'b0;
  endtask

  task automatic start(input logic [3:0] vx, input logic [3:0] vy, input logic dx, input logic dy);
    bus.vel_x = vx; bus.vel_y = vy; bus.dir_x = dx; bus.dir_y = dy;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
  endtask

  // Full operation from acceptance through return to idle, checking timing and result.
  task automatic run_op(input string tag, input logic [3:0] vx, input logic [3:0] vy,
                        input logic dx, input logic dy, input logic [3:0] ex, input logic [3:0] ey,
                        input logic ewx, input logic ewy);
    start(vx, vy, dx, dy);
    chk({tag, ".busy1"}, bus.ocupado, 1);
    chk({tag, ".pronto1"}, bus.pronto, 0);
    tick();
    chk({tag, ".pronto2"}, bus.pronto, 0);
    tick();
    chk({tag, ".pronto3"}, bus.pronto, 1);
    chk({tag, ".pos_x"}, bus.pos_x, ex);
    chk({tag, ".pos_y"}, bus.pos_y, ey);
    chk({tag, ".wrap_x"}, bus.wrap_x, ewx);
    chk({tag, ".wrap_y"}, bus.wrap_y, ewy);
    tick();
    chk({tag, ".idle"}, bus.ocupado, 0);
    chk({tag, ".pronto_off"}, bus.pronto, 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    bus.carregar = 1'b0; bus.iniciar = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.vel_x = '0; bus.vel_y = '0;
    bus.dir_x = 1'b0; bus.dir_y = 1'b0;

    tick(); tick();
    reset = 1'b0;
    chk("rst.pos_x", bus.pos_x, 0);
    chk("rst.pos_y", bus.pos_y, 0);
    chk("rst.ocupado", bus.ocupado, 0);
    chk("rst.pronto", bus.pronto, 0);
    chk("rst.wrap_x", bus.wrap_x, 0);
    chk("rst.wrap_y", bus.wrap_y, 0);

    load(4'd3, 4'd1);
    chk("load.pos_x", bus.pos_x, 3);
    chk("load.pos_y", bus.pos_y, 1);
    run_op("basic", 4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 4'd3, 1'b0, 1'b0);

    // 14+3 = 17 -> 1 with carry; 2-5 = -3 -> 13 with borrow
    load(4'd14, 4'd2);
    run_op("wrap", 4'd3, 4'd5, 1'b1, 1'b0, 4'd1, 4'd13, 1'b1, 1'b1);

    load(4'd5, 4'd5);
    chk("load.clr_wrap_x", bus.wrap_x, 0);
    chk("load.clr_wrap_y", bus.wrap_y, 0);

    // Requests and operand changes while busy must be ignored.
    start(4'd2, 4'd2, 1'b0, 1'b1);
    tick();
    bus.iniciar = 1'b1; bus.carregar = 1'b1; bus.x_in = 4'd9;
    bus.vel_y = 4'd7; bus.dir_y = 1'b0;
    tick();
    bus.iniciar = 1'b0; bus.carregar = 1'b0;
    chk("busy.pronto", bus.pronto, 1);
    chk("busy.pos_x", bus.pos_x, 3);
    chk("busy.pos_y", bus.pos_y, 7);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.pronto) pulses++;
    end
    chk("busy.extra_pronto", pulses, 0);
    chk("busy.no_reload", bus.pos_x, 3);

    // Reset during CALC_Y
    load(4'd6, 4'd6);
    start(4'd1, 4'd1, 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst.pos_x", bus.pos_x, 0);
    chk("midrst.pos_y", bus.pos_y, 0);
    chk("midrst.ocupado", bus.ocupado, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.pronto) pulses++;
    end
    chk("midrst.no_pronto", pulses, 0);

    // carregar wins over iniciar
    bus.vel_x = 4'd0; bus.vel_y = 4'd0; bus.dir_x = 1'b0; bus.dir_y = 1'b1;
    bus.x_in = 4'd7; bus.y_in = 4'd7;
    bus.carregar = 1'b1; bus.iniciar = 1'b1;
    tick();
    bus.carregar = 1'b0; bus.iniciar = 1'b0;
    chk("prio.pos_x", bus.pos_x, 7);
    chk("prio.pos_y", bus.pos_y, 7);
    chk("prio.ocupado", bus.ocupado, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.pronto) pulses++;
    end
    chk("prio.no_pronto", pulses, 0);
    run_op("zero", 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
